// File: rtl/cmd_rcv.sv
// cmd_rcv: 8N1 serial receiver that assembles three accepted bytes into one 24-bit command frame.
// Latency: cfg_data/frm_rdy update one clock after the stop-bit sample of the third byte.
// Backpressure: none; a frame arriving while frm_rdy is still set overwrites cfg_data and sets sticky frm_ovr.
// Optional: define CMD_RCV_TIMEOUT_EN to drop partial frames after TIMEOUT_CYC idle clocks.
module cmd_rcv #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_rdy,
  output logic [23:0] cfg_data,
  output logic        frm_rdy,
  output logic        frm_ovr
);

  localparam int CW = 12;
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

  // Reject parameter values the 12-bit baud counter cannot represent.
  if (BAUD_DIV < 16 || BAUD_DIV > 4095 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cmd_rcv: BAUD_DIV must be 16..4095 and TIMEOUT_CYC positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shr_q, shr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic          done_q, done_d;
  logic [23:0]   cfg_q, cfg_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;
  logic          fall;
  logic          tick;

  // A counter value of 1 marks the last clock of the current interval, so a
  // reload of N gives an exact N-clock period with no doubled or skipped sample.
  assign fall = rx_prev_q & ~rx_sync_q;
  assign tick = (cnt_q == CW'(1));

`ifdef CMD_RCV_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        timeout_hit;

  assign timeout_hit = (idle_q == 32'(TIMEOUT_CYC));

  // Idle counter runs only while a partial frame waits in IDLE; any start edge restarts it.
  always_comb begin
    idle_d = idle_q;
    if (state_q != S_IDLE || byte_cnt_q == 2'd0 || fall) begin
      idle_d = '0;
    end else if (!timeout_hit) begin
      idle_d = idle_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  // Two-flop synchronizer plus one history flop for start-edge detection; idle level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next-state: bit timing, byte shifting and frame assembly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shr_d      = shr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = BAUD_HALF;
        end
`ifdef CMD_RCV_TIMEOUT_EN
        else if (timeout_hit) begin
          byte_cnt_d = 2'd0;
        end
`endif
      end
      S_START: begin
        if (tick) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d   = S_DATA;
            cnt_d     = BAUD_FULL;
            bit_cnt_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shr_d     = {rx_sync_q, shr_q[7:1]};
          cnt_d     = BAUD_FULL;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (rx_sync_q) begin
            case (byte_cnt_q)
              2'd0: begin
                asm_d[23:16] = shr_q;
                byte_cnt_d   = 2'd1;
              end
              2'd1: begin
                asm_d[15:8] = shr_q;
                byte_cnt_d  = 2'd2;
              end
              default: begin
                asm_d[7:0] = shr_q;
                byte_cnt_d = 2'd0;
                done_d     = 1'b1;
              end
            endcase
          end else begin
            // Framing error: the whole partial frame is abandoned.
            byte_cnt_d = 2'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shr_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shr_q      <= shr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
    end
  end

  // Output frame handoff: completion sets ready (winning over a clear) and flags overruns.
  always_comb begin
    cfg_d = cfg_q;
    rdy_d = rdy_q;
    ovr_d = ovr_q;
    if (clr_rdy) begin
      rdy_d = 1'b0;
    end
    if (done_q) begin
      cfg_d = asm_q;
      rdy_d = 1'b1;
      if (rdy_q && !clr_rdy) begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
    end
  end

  assign cfg_data = cfg_q;
  assign frm_rdy  = rdy_q;
  assign frm_ovr  = ovr_q;

endmodule

// File: doc/cmd_rcv.md
CMD_RCV -- requirements
Module: cmd_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per serial bit; legal range 16..4095.
REQ-002 Parameter TIMEOUT_CYC, default 500000, idle clocks allowed between bytes of a partial frame.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 clr_rdy  input  1  consumer's request to clear frm_rdy (pulse).
REQ-007 cfg_data  output  24  last complete command frame; first received byte in [23:16], last byte in [7:0].
REQ-008 frm_rdy  output  1  a complete frame is present in cfg_data.
REQ-009 frm_ovr  output  1  sticky: a frame completed while frm_rdy was already 1.

Function
REQ-010 The block shall pass RX through a two-flop synchronizer that resets to 1; all decoding uses the synchronized signal.
REQ-011 Receiver FSM states shall be IDLE, START, DATA, STOP.
REQ-012 IDLE->START on a synchronized RX falling edge; the baud counter loads BAUD_DIV/2 (integer division).
REQ-013 START: at counter expiry, sample RX; if 1 (false start), go to IDLE; if 0, go to DATA with the counter reloaded to BAUD_DIV.
REQ-014 DATA: sample RX at each BAUD_DIV expiry and shift it into a byte register LSB-first; after the 8th sample, go to STOP.
REQ-015 STOP: sample at expiry; if 1, the byte is accepted; if 0 (framing error), discard the byte, clear the byte count to 0, and go to IDLE without waiting for the line to go high.
REQ-016 Accepted bytes shall fill a 24-bit assembly register MSB byte first; a 2-bit byte count runs 0->1->2.
REQ-017 On acceptance of byte count 2: on the next clock edge, cfg_data loads the assembled 24 bits, frm_rdy goes to 1, and the byte count returns to 0 (one-cycle latency from stop-bit sample).
REQ-018 cfg_data shall hold its value until the next completed frame; partial frames never alter it.
REQ-019 frm_rdy shall clear on the clock edge after clr_rdy=1; if frame completion and clr_rdy occur in the same cycle, frm_rdy shall be 1 (set wins).
REQ-020 If a frame completes while frm_rdy=1 and clr_rdy=0, cfg_data is overwritten, frm_rdy stays 1, and frm_ovr is set; frm_ovr clears only on reset.
REQ-021 After the STOP state, the FSM shall return to IDLE and may detect the next start edge immediately; back-to-back frames with no idle gap shall be received without loss.
REQ-022 The baud counter shall count down and reload; no bit shall be sampled twice or skipped at counter wrap.

Reset
REQ-023 On reset assertion, outputs shall be: cfg_data=24'h000000, frm_rdy=0, frm_ovr=0; FSM=IDLE; byte count=0; synchronizer=1; counters=0.
REQ-024 Reset asserted mid-byte or mid-frame shall discard all partial data; after release, reception restarts at the next start edge.

Configuration
REQ-025 Macro CMD_RCV_TIMEOUT_EN: when defined, an idle counter runs while the FSM is in IDLE with byte count ≠ 0; when it reaches TIMEOUT_CYC, the byte count clears to 0 and the partial frame is dropped. The counter clears on any start edge.
REQ-026 Without CMD_RCV_TIMEOUT_EN, no idle counter exists; a partial frame waits indefinitely for its remaining bytes.

Verification (bench BAUD_DIV=16, TIMEOUT_CYC=1000)
REQ-027 Send bytes 0x03,0x00,0x00 -> cfg_data=24'h030000 and frm_rdy=1 one clock after the third stop sample; pulse clr_rdy -> frm_rdy=0 on the next edge.
REQ-028 Send 0x08,0x12,0x34, no clr_rdy, then send 0x0C,0x00,0x00 -> cfg_data=24'h0C0000, frm_rdy=1, frm_ovr=1.
REQ-029 A 4-clock low glitch on RX, then bytes 0xA5,0x5A,0xFF -> glitch ignored; cfg_data=24'hA55AFF.
REQ-030 Send 0x11 with stop bit forced 0, then 0x22,0x33,0x44 -> cfg_data=24'h223344 (0x11 discarded).
REQ-031 With CMD_RCV_TIMEOUT_EN: send 0x55, idle 1200 clocks, then send 0x01,0x02,0x03 -> cfg_data=24'h010203. Without the macro, the same stimulus gives cfg_data=24'h550102.
REQ-032 Assert rst_n low mid-second byte, release, then send 0x03,0x00,0x00 -> cfg_data=24'h030000 and frm_ovr=0.
